// File: rtl/cache_stage3_pkg.sv
// Shared types and constants for the L1 cache stage-3 miss controller.
package cache_stage3_pkg;

  localparam int unsigned TAG_WIDTH_DEF  = 39;
  localparam int unsigned INDEX_W_DEF    = 7;
  localparam int unsigned OFFSET_W_DEF   = 6;
  localparam int unsigned BEAT_BYTES_DEF = 8;
  localparam int unsigned LINE_BEATS     = (2 ** OFFSET_W_DEF) / BEAT_BYTES_DEF;
  localparam int unsigned BEAT_W         = $clog2(LINE_BEATS);

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_READ_REQ   = 4'd1,
    S_READ_RESP  = 4'd2,
    S_WRITE_REQ  = 4'd3,
    S_WRITE_RESP = 4'd4,
    S_MMIO_REQ   = 4'd5,
    S_MMIO_RESP  = 4'd6,
    S_WAIT_RESP  = 4'd7,
    S_RELEASE    = 4'd8
  } state_t;

  typedef enum logic [1:0] {
    CMD_READ_BURST  = 2'd0,
    CMD_WRITE_BURST = 2'd1,
    CMD_READ_SINGLE = 2'd2
  } mem_cmd_t;

  // Line-aligned address {tag, index, zero offset}; caller truncates to its address width.
  function automatic logic [63:0] line_addr(input logic [63:0] tag, input logic [63:0] index,
                                            input int unsigned index_w,
                                            input int unsigned offset_w);
    return (tag << (index_w + offset_w)) | (index << offset_w);
  endfunction

endpackage

// File: rtl/cache_beat_counter.sv
// Beat index shared by refill and writeback bursts; clear has priority over increment.
module cache_beat_counter
  import cache_stage3_pkg::*;
#(
  parameter int unsigned  BEATS = LINE_BEATS,
  localparam int unsigned W     = $clog2(BEATS)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         last_c
);

  assign last_c = (cnt == W'(BEATS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= last_c ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/cache_stage3_miss_fsm.sv
// Stage-3 cache controller: sequences dirty writeback, line refill and MMIO,
// then returns one response per accepted request.
module cache_stage3_miss_fsm
  import cache_stage3_pkg::*;
#(
  parameter int unsigned  TAG_WIDTH  = TAG_WIDTH_DEF,
  parameter int unsigned  INDEX_W    = INDEX_W_DEF,
  parameter int unsigned  OFFSET_W   = OFFSET_W_DEF,
  parameter int unsigned  BEAT_BYTES = BEAT_BYTES_DEF,
  localparam int unsigned ADDR_W     = TAG_WIDTH + INDEX_W + OFFSET_W,
  localparam int unsigned BEATS      = (2 ** OFFSET_W) / BEAT_BYTES,
  localparam int unsigned CNT_W      = $clog2(BEATS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ADDR_W-1:0]    in_addr,
  input  logic                 in_hit,
  input  logic                 in_miss,
  input  logic                 in_mmio,
  input  logic [1:0]           in_flush,
  input  logic                 meta_dirty,
  input  logic [TAG_WIDTH-1:0] meta_tag,
  output logic                 mem_req_valid,
  input  logic                 mem_req_ready,
  output logic [1:0]           mem_req_cmd,
  output logic [ADDR_W-1:0]    mem_req_addr,
  output logic                 mem_req_wlast,
  input  logic                 mem_resp_valid,
  input  logic                 mem_resp_last,
  output logic                 refill_wen,
  output logic [CNT_W-1:0]     beat_cnt,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_mmio,
  output logic [3:0]           main_state
);

  state_t                state;
  logic                  drop;
  logic [ADDR_W-1:0]     addr_q;
  logic [TAG_WIDTH-1:0]  vtag_q;
  logic                  mmio_q;
  logic                  accept;
  logic                  release_next;
  logic                  cnt_clr;
  logic                  cnt_inc;
  logic                  cnt_last;
  logic [INDEX_W-1:0]    index;
  logic [TAG_WIDTH-1:0]  req_tag;

  assign index        = addr_q[OFFSET_W +: INDEX_W];
  assign req_tag      = addr_q[ADDR_W-1 -: TAG_WIDTH];
  assign accept       = in_valid && (state == S_IDLE);
  assign release_next = drop || in_flush[0];

  cache_beat_counter #(.BEATS(BEATS)) u_beat_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (cnt_clr),
    .inc    (cnt_inc),
    .cnt    (beat_cnt),
    .last_c (cnt_last)
  );

  // Counter restarts on every accept so a short refill never leaks into the next burst.
  always_comb begin
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    case (state)
      S_IDLE:      cnt_clr = accept;
      S_READ_REQ:  cnt_clr = mem_req_ready;
      S_READ_RESP: cnt_inc = mem_resp_valid;
      S_WRITE_REQ: begin
        cnt_clr = mem_req_ready && cnt_last;
        cnt_inc = mem_req_ready && !cnt_last;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      drop   <= 1'b0;
      addr_q <= '0;
      vtag_q <= '0;
      mmio_q <= 1'b0;
    end else begin
      if ((state != S_IDLE) && in_flush[0]) drop <= 1'b1;
      case (state)
        S_IDLE: begin
          if (accept && !in_flush[1]) begin
            addr_q <= in_addr;
            vtag_q <= meta_tag;
            mmio_q <= in_mmio;
            if (in_mmio)                   state <= S_MMIO_REQ;
            else if (in_hit)               state <= S_WAIT_RESP;
            else if (in_miss && meta_dirty) state <= S_WRITE_REQ;
            else if (in_miss)              state <= S_READ_REQ;
          end
        end
        S_READ_REQ:   if (mem_req_ready) state <= S_READ_RESP;
        S_READ_RESP: begin
          if (mem_resp_valid && mem_resp_last)
            state <= release_next ? S_RELEASE : S_WAIT_RESP;
        end
        S_WRITE_REQ:  if (mem_req_ready && cnt_last) state <= S_WRITE_RESP;
        S_WRITE_RESP: if (mem_resp_valid) state <= S_READ_REQ;
        S_MMIO_REQ:   if (mem_req_ready) state <= S_MMIO_RESP;
        S_MMIO_RESP: begin
          if (mem_resp_valid) state <= release_next ? S_RELEASE : S_WAIT_RESP;
        end
        S_WAIT_RESP: begin
          if (out_ready)        state <= S_IDLE;
          else if (in_flush[0]) state <= S_RELEASE;
        end
        S_RELEASE: begin
          drop  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Handshake outputs decode the state register only, except the refill strobe
  // which must line up with the arriving beat.
  always_comb begin
    mem_req_valid = 1'b0;
    mem_req_cmd   = CMD_READ_BURST;
    mem_req_addr  = '0;
    mem_req_wlast = 1'b0;
    case (state)
      S_READ_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_cmd   = CMD_READ_BURST;
        mem_req_addr  = ADDR_W'(line_addr(64'(req_tag), 64'(index), INDEX_W, OFFSET_W));
      end
      S_WRITE_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_cmd   = CMD_WRITE_BURST;
        mem_req_addr  = ADDR_W'(line_addr(64'(vtag_q), 64'(index), INDEX_W, OFFSET_W));
        mem_req_wlast = cnt_last;
      end
      S_MMIO_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_cmd   = CMD_READ_SINGLE;
        mem_req_addr  = addr_q;
      end
      default: ;
    endcase
  end

  assign in_ready   = (state == S_IDLE);
  assign refill_wen = (state == S_READ_RESP) && mem_resp_valid;
  assign out_valid  = (state == S_WAIT_RESP);
  assign out_mmio   = (state == S_WAIT_RESP) && mmio_q;
  assign main_state = state;

endmodule

// File: doc/cache_stage3_miss_fsm.md
Name: cache_stage3_miss_fsm

Overview:
Stage-3 main controller of the L1 cache. It takes the resolved lookup from stage 2 (hit, miss, mmio, victim metadata) and sequences the memory traffic: dirty-victim writeback, line refill and uncached MMIO access. It then returns one response per accepted request. Its state and handshake outputs feed the stage-3 assertion checker and the data/meta array write ports.

Parameters:
TAG_WIDTH, 39, victim/request tag width
INDEX_W, 7, set index width
OFFSET_W, 6, byte offset within line (64 B line)
BEAT_BYTES, 8, bytes per memory beat; LINE_BEATS = 2**OFFSET_W / BEAT_BYTES = 8
ADDR_W, TAG_WIDTH+INDEX_W+OFFSET_W (52), physical address width (derived, not overridable)

Ports:
clk  in  1  clock
rst_n  in  1  reset
in_valid  in  1  stage-2 request valid
in_ready  out  1  request accepted this cycle when in_valid&&in_ready
in_addr  in  ADDR_W  request physical address
in_hit  in  1  lookup hit
in_miss  in  1  lookup miss
in_mmio  in  1  uncached access
in_flush  in  2  [0] drop in-flight response, [1] kill incoming request
meta_dirty  in  1  victim line dirty
meta_tag  in  TAG_WIDTH  victim tag
mem_req_valid  out  1  memory request valid
mem_req_ready  in  1  memory accepts request/beat
mem_req_cmd  out  2  0 read burst, 1 write burst, 2 single read
mem_req_addr  out  ADDR_W  request address
mem_req_wlast  out  1  last write beat
mem_resp_valid  in  1  response beat / write ack
mem_resp_last  in  1  final read beat
refill_wen  out  1  write current beat into data array
beat_cnt  out  $clog2(LINE_BEATS)  beat index for array/write data
out_valid  out  1  response to pipeline
out_ready  in  1  pipeline takes response
out_mmio  out  1  response came from MMIO path
main_state  out  4  current FSM state encoding

Behaviour:
- Reset is asynchronous and active-low (rst_n); clock is clk, single clock domain.
- In reset: state IDLE, beat_cnt 0, drop flag 0, latched address/tag 0. All outputs 0 except in_ready=1.
- States and encodings: IDLE 0, READ_REQ 1, READ_RESP 2, WRITE_REQ 3, WRITE_RESP 4, MMIO_REQ 5, MMIO_RESP 6, WAIT_RESP 7, RELEASE 8. main_state is a registered output equal to the state register.
- in_ready = (state==IDLE). On accept, latch addr, mmio, dirty and tag.
- Transitions out of IDLE (priority order):
  - in_flush[1]: request dropped, stay IDLE.
  - mmio: go to MMIO_REQ.
  - hit: go to WAIT_RESP.
  - miss&&dirty: go to WRITE_REQ.
  - miss: go to READ_REQ.
- Illegal inputs: hit&&miss and hit&&mmio. Behaviour is undefined, and the checker flags both.
- READ_REQ: mem_req_valid=1, cmd=0, addr={tag,index,0}. On ready, go to READ_RESP with beat_cnt=0.
- READ_RESP: for each mem_resp_valid, refill_wen=1 and beat_cnt++ (wraps modulo LINE_BEATS). On mem_resp_last, go to WAIT_RESP. mem_resp_last is authoritative, so a short burst still ends the refill.
- WRITE_REQ: mem_req_valid=1, cmd=1, addr={meta_tag,index,0}. One beat per handshake; beat_cnt increments on each handshake. wlast=1 when beat_cnt==LINE_BEATS-1. The last handshake clears beat_cnt and moves to WRITE_RESP.
- WRITE_RESP: mem_resp_valid moves to READ_REQ, giving a refill exactly one cycle after the ack. mem_req_valid=0 in this state.
- MMIO_REQ: cmd=2, full unaligned address. On ready, go to MMIO_RESP. MMIO_RESP: mem_resp_valid moves to WAIT_RESP.
- WAIT_RESP: out_valid=1, out_mmio=latched mmio. out_valid holds until out_ready; the handshake returns to IDLE. Minimum hit latency: accept at cycle N gives out_valid at N+1.
- Flush handling:
  - in_flush[0] in any non-IDLE state sets the drop flag. The bus transaction still completes; requests are never abandoned mid-burst.
  - With the drop flag set, the entry into WAIT_RESP is replaced by RELEASE. RELEASE lasts one cycle, out_valid=0, and clears the flag before returning to IDLE.
  - in_flush[0] asserted in WAIT_RESP retracts out_valid in the next cycle.
- mem_req_valid is only asserted in states 1, 3 and 5. Once asserted, it holds with stable cmd/addr until ready.
- Asynchronous reset mid-burst returns to IDLE immediately. The memory side must also be reset.

Decomposition:
- Package cache_stage3_pkg:
  - state enum (4-bit, values 0–8)
  - mem_cmd enum (2-bit)
  - LINE_BEATS and BEAT_W localparams
  - helper to form a line-aligned address from tag and index
- One sub-module, cache_beat_counter: $clog2(LINE_BEATS) counter with clear, increment and last-beat flag. It is shared by the refill and writeback paths.

Test Plan:
- Hit: in_valid, in_hit=1, out_ready=1 at cycle 0 → main_state 0→7→0, out_valid high exactly at cycle 1, no mem_req_valid.
- Clean miss, addr 0x40, 8 beats, ready always 1 → state 1 (one cycle, cmd=0, addr 0x40), then state 2. refill_wen pulses for beat_cnt 0..7, last at beat 7 → state 7 → out_valid.
- Dirty miss, meta_tag=0x5, index 3 → state 3 issues 8 write beats to addr {0x5,3,0} with wlast only on beat 7. State 4 waits for the ack, then state 1, then refill as above.
- MMIO, addr 0x1004, mem_req_ready low 3 cycles → mem_req_valid and addr 0x1004 stable for 4 cycles, cmd=2. Response gives out_valid with out_mmio=1.
- in_flush[0] pulsed during READ_RESP beat 2 → burst finishes all 8 beats, state passes through 8, no out_valid. Concurrently, in_flush[1] with in_valid in IDLE → no state change.
- rst_n low during WRITE_REQ beat 4 → next edge state 0, beat_cnt 0, all outputs 0. After release, a new clean miss completes normally.
